rvv_vd_collector: RTL and testbench

Write-back collector downstream of the lane ALU wrapper. Each beat it takes the per-lane result chunks, bit indices and lane-valid flags, and merges them into a VLEN-bit destination buffer. Elements at or above `vl` keep the old destination value (tail-undisturbed). When the producer signals done, it presents the assembled register to the vector register file over a valid/ready handshake.

---
 rtl/rvv_vd_collector_pkg.sv | 28 ++
 rtl/rvv_chunk_merge.sv | 52 +++++
 rtl/rvv_vd_collector.sv | 112 +++++++++++
 tb/tb_rvv_vd_collector.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rvv_vd_collector_pkg.sv
// Shared types and width helpers for the vector destination write-back collector.
// State encoding plus element/chunk width helpers used by the top and the merge unit.
package rvv_vd_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } state_e;

  function automatic logic [10:0] ew_bits(input logic [2:0] vsew);
    ew_bits = 11'd8 << vsew;
  endfunction

  // Chunk width is the element width capped by the lane datapath width.
  function automatic logic [10:0] chunk_bits(input logic [2:0] vsew, input int lane_width);
    logic [10:0] cap;
    logic [10:0] ew;
    cap = 11'd1 << lane_width;
    ew  = ew_bits(vsew);
    if (ew < cap) begin
      chunk_bits = ew;
    end else begin
      chunk_bits = cap;
    end
  endfunction

endpackage

// File: rtl/rvv_chunk_merge.sv
// Combinational merge of all enabled lane chunks into the destination buffer.
// Lanes are applied in ascending order so the highest-numbered lane wins on overlap.
module rvv_chunk_merge
  import rvv_vd_collector_pkg::*;
#(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1
) (
  input  logic [VLEN-1:0]               cur_buf,
  input  logic [64*(1<<NB_LANES)-1:0]   lane_vd,
  input  logic [10*(1<<NB_LANES)-1:0]   lane_idx,
  input  logic [(1<<NB_LANES)-1:0]      lane_en,
  input  logic [10:0]                   width,
  input  logic [9:0]                    vl,
  input  logic [2:0]                    vsew,
  output logic [VLEN-1:0]               next_buf
);

  localparam int L = 1 << NB_LANES;

  logic [9:0]      idx_s;
  logic [9:0]      elem_s;
  logic [11:0]     end_bit_s;
  logic [63:0]     lo_mask_s;
  logic [VLEN-1:0] chunk_mask_s;
  logic [VLEN-1:0] chunk_data_s;

  // Apply each lane's chunk; out-of-range or tail chunks leave the buffer untouched.
  always_comb begin
    next_buf     = cur_buf;
    idx_s        = 10'd0;
    elem_s       = 10'd0;
    end_bit_s    = 12'd0;
    lo_mask_s    = 64'd0;
    chunk_mask_s = '0;
    chunk_data_s = '0;
    for (int k = 0; k < L; k++) begin
      idx_s        = lane_idx[10*k +: 10];
      elem_s       = idx_s >> ({1'b0, vsew} + 4'd3);
      end_bit_s    = {2'b00, idx_s} + {1'b0, width};
      lo_mask_s    = (64'd1 << width) - 64'd1;
      chunk_mask_s = VLEN'(lo_mask_s) << idx_s;
      chunk_data_s = VLEN'(lane_vd[64*k +: 64] & lo_mask_s) << idx_s;
      if (lane_en[k] && (elem_s < vl) && (end_bit_s <= 12'(VLEN))) begin
        next_buf = (next_buf & ~chunk_mask_s) | chunk_data_s;
      end else begin
        next_buf = next_buf;
      end
    end
  end

endmodule

// File: rtl/rvv_vd_collector.sv
// Vector destination write-back collector: merges lane result chunks into a
// VLEN-bit buffer (tail-undisturbed) and hands it to the register file.
module rvv_vd_collector
  import rvv_vd_collector_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic [4:0]                      vd_addr,
  input  logic [VLEN-1:0]                 old_vd,
  input  logic [2:0]                      vsew,
  input  logic [9:0]                      vl,
  input  logic                            beat_valid,
  input  logic [64*(1<<NB_LANES)-1:0]     lane_vd,
  input  logic [10*(1<<NB_LANES)-1:0]     lane_idx,
  input  logic [(1<<NB_LANES)-1:0]        lane_en,
  input  logic                            done_in,
  output logic                            busy,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [4:0]                      wr_addr,
  output logic [VLEN-1:0]                 wr_data,
  output logic                            wb_done
);

  state_e          state_r, state_n;
  logic [VLEN-1:0] vbuf_r, merged_s;
  logic [4:0]      addr_r;
  logic [2:0]      vsew_r;
  logic [9:0]      vl_r;
  logic [10:0]     width_s;
  logic            busy_r, wr_valid_r, wb_done_r;
  logic            busy_s, wr_valid_s, wb_done_s;

  assign width_s = chunk_bits(vsew_r, LANE_WIDTH);

  rvv_chunk_merge #(.VLEN(VLEN), .NB_LANES(NB_LANES)) u_merge (
    .cur_buf  (vbuf_r),
    .lane_vd  (lane_vd),
    .lane_idx (lane_idx),
    .lane_en  (lane_en),
    .width    (width_s),
    .vl       (vl_r),
    .vsew     (vsew_r),
    .next_buf (merged_s)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE:    if (start) state_n = ST_COLLECT; else state_n = ST_IDLE;
      ST_COLLECT: if (beat_valid && done_in) state_n = ST_WRITE; else state_n = ST_COLLECT;
      ST_WRITE:   if (wr_ready) state_n = ST_IDLE; else state_n = ST_WRITE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Output decode, looking one state ahead so the flops below line up with state_r
  always_comb begin
    busy_s     = (state_n != ST_IDLE);
    wr_valid_s = (state_n == ST_WRITE);
    wb_done_s  = (state_r == ST_WRITE) && wr_ready;
  end

  // Registered handshake outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r     <= 1'b0;
      wr_valid_r <= 1'b0;
      wb_done_r  <= 1'b0;
    end else begin
      busy_r     <= busy_s;
      wr_valid_r <= wr_valid_s;
      wb_done_r  <= wb_done_s;
    end
  end

  // Buffer and captured instruction fields
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vbuf_r <= '0;
      addr_r <= 5'd0;
      vsew_r <= 3'd0;
      vl_r   <= 10'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      vbuf_r <= old_vd;
      addr_r <= vd_addr;
      vsew_r <= vsew;
      vl_r   <= vl;
    end else if ((state_r == ST_COLLECT) && beat_valid) begin
      vbuf_r <= merged_s;
    end
  end

  assign busy     = busy_r;
  assign wr_valid = wr_valid_r;
  assign wb_done  = wb_done_r;
  assign wr_addr  = addr_r;
  assign wr_data  = vbuf_r;

endmodule

// File: tb/tb_rvv_vd_collector.sv
// Directed self-checking bench for rvv_vd_collector (VLEN=128, two lanes, 8-bit chunks).
module tb_rvv_vd_collector;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [4:0]   vd_addr;
  logic [127:0] old_vd;
  logic [2:0]   vsew;
  logic [9:0]   vl;
  logic         beat_valid;
  logic [127:0] lane_vd;
  logic [19:0]  lane_idx;
  logic [1:0]   lane_en;
  logic         done_in;
  logic         busy;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_addr;
  logic [127:0] wr_data;
  logic         wb_done;

  int total = 0;
  int bad   = 0;

  rvv_vd_collector #(.VLEN(128), .LANE_WIDTH(3), .NB_LANES(1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .vd_addr(vd_addr), .old_vd(old_vd),
    .vsew(vsew), .vl(vl), .beat_valid(beat_valid), .lane_vd(lane_vd),
    .lane_idx(lane_idx), .lane_en(lane_en), .done_in(done_in), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wb_done(wb_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] a, input logic [127:0] o,
                          input logic [2:0] s, input logic [9:0] v);
    start = 1'b1; vd_addr = a; old_vd = o; vsew = s; vl = v;
    tick();
    start = 1'b0; old_vd = '0;
  endtask

  task automatic beat(input logic [63:0] d0, input logic [9:0] i0,
                      input logic [63:0] d1, input logic [9:0] i1,
                      input logic [1:0] en, input logic done);
    beat_valid = 1'b1; lane_vd = {d1, d0}; lane_idx = {i1, i0}; lane_en = en; done_in = done;
    tick();
    beat_valid = 1'b0; lane_en = 2'b00; done_in = 1'b0;
  endtask

  task automatic accept();
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL reset_wb_done got=%b exp=0", wb_done); end
    total++; if (wr_addr !== 5'd0) begin bad++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
    total++; if (wr_data !== 128'd0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
  endtask

  task automatic test_full_bytes();
    do_start(5'd9, {128{1'b1}}, 3'd0, 10'd16);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b exp=1", busy); end
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%b exp=0", wr_valid); end
    for (int j = 0; j < 8; j++)
      beat(64'(2*j), 10'(16*j), 64'(2*j+1), 10'(16*j+8), 2'b11, (j == 7));
    total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL full_wr_valid got=%b exp=1", wr_valid); end
    total++; if (wr_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin bad++; $display("FAIL full_data got=%h exp=%h", wr_data, 128'h0F0E0D0C0B0A09080706050403020100); end
    total++; if (wr_addr !== 5'd9) begin bad++; $display("FAIL full_addr got=%h exp=09", wr_addr); end
    accept();
    total++; if (wb_done !== 1'b1) begin bad++; $display("FAIL full_wb_done got=%b exp=1", wb_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_fall got=%b exp=0", busy); end
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL full_valid_fall got=%b exp=0", wr_valid); end
    tick();
    total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL full_wb_done_pulse got=%b exp=0", wb_done); end
  endtask

  task automatic test_tail_and_hold();
    logic [127:0] exp;
    exp = {{11{8'hFF}}, 40'h0403020100};
    do_start(5'd3, {128{1'b1}}, 3'd0, 10'd5);
    for (int j = 0; j < 8; j++)
      beat(64'(2*j), 10'(16*j), 64'(2*j+1), 10'(16*j+8), 2'b11, (j == 7));
    for (int c = 0; c < 4; c++) begin
      total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", c, wr_valid); end
      total++; if (wr_data !== exp) begin bad++; $display("FAIL hold_data cyc=%0d got=%h exp=%h", c, wr_data, exp); end
      total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL hold_wb_done cyc=%0d got=%b exp=0", c, wb_done); end
      tick();
    end
    accept();
    total++; if (wb_done !== 1'b1) begin bad++; $display("FAIL hold_accept got=%b exp=1", wb_done); end
    tick();
  endtask

  task automatic test_wide_elements();
    logic [127:0] e;
    e = 128'h99AABBCCDDEEFF00_1122334455667788;
    do_start(5'd17, {128{1'b1}}, 3'd3, 10'd2);
    for (int j = 0; j < 8; j++)
      beat({56'hDEADBEEFCAFEF0, e[16*j +: 8]}, 10'(16*j),
           {56'h0123456789ABCD, e[16*j+8 +: 8]}, 10'(16*j+8), 2'b11, (j == 7));
    total++; if (wr_data !== 128'h99AABBCCDDEEFF00_1122334455667788) begin bad++; $display("FAIL wide_data got=%h exp=%h", wr_data, e); end
    accept();
    do_start(5'd18, 128'd0, 3'd3, 10'd1);
    for (int j = 0; j < 8; j++)
      beat({56'd0, e[16*j +: 8]}, 10'(16*j), {56'd0, e[16*j+8 +: 8]}, 10'(16*j+8), 2'b11, (j == 7));
    total++; if (wr_data !== {64'd0, 64'h1122334455667788}) begin bad++; $display("FAIL wide_tail got=%h exp=%h", wr_data, {64'd0, 64'h1122334455667788}); end
    accept();
    tick();
  endtask

  task automatic test_reset_mid();
    do_start(5'd4, 128'h1234, 3'd0, 10'd16);
    beat(64'h77, 10'd0, 64'h66, 10'd8, 2'b11, 1'b0);
    #2 resetn = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (wr_data !== 128'd0) begin bad++; $display("FAIL rst_mid_data got=%h exp=0", wr_data); end
    total++; if (wr_addr !== 5'd0) begin bad++; $display("FAIL rst_mid_addr got=%h exp=0", wr_addr); end
    tick();
    resetn = 1'b1;
    tick();
    do_start(5'd12, {16{8'hAA}}, 3'd0, 10'd16);
    beat(64'h55, 10'd0, 64'h55, 10'd8, 2'b00, 1'b1);
    total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL rst_new_valid got=%b exp=1", wr_valid); end
    total++; if (wr_data !== {16{8'hAA}}) begin bad++; $display("FAIL rst_new_data got=%h exp=%h", wr_data, {16{8'hAA}}); end
    accept();
    total++; if (wb_done !== 1'b1) begin bad++; $display("FAIL rst_new_wb_done got=%b exp=1", wb_done); end
    tick();
  endtask

  task automatic test_edges();
    logic [127:0] o;
    o = 128'h0123456789ABCDEF_FEDCBA9876543210;
    do_start(5'd5, o, 3'd0, 10'd0);
    beat(64'h5A, 10'd0, 64'h77, 10'd16, 2'b01, 1'b1);
    total++; if (wr_data !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin bad++; $display("FAIL vl0_data got=%h exp=%h", wr_data, o); end
    total++; if (wr_addr !== 5'd5) begin bad++; $display("FAIL vl0_addr got=%h exp=05", wr_addr); end
    accept();
    tick();
    beat(64'h33, 10'd0, 64'h44, 10'd8, 2'b11, 1'b1);
    total++; if (wr_data !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin bad++; $display("FAIL idle_beat_data got=%h exp=%h", wr_data, o); end
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL idle_beat_valid got=%b exp=0", wr_valid); end
    do_start(5'd7, o, 3'd0, 10'd1000);
    do_start(5'd3, 128'd0, 3'd0, 10'd16);
    total++; if (wr_addr !== 5'd7) begin bad++; $display("FAIL restart_addr got=%h exp=07", wr_addr); end
    total++; if (wr_data !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin bad++; $display("FAIL restart_data got=%h exp=%h", wr_data, o); end
    beat(64'h55, 10'd124, 64'h66, 10'd0, 2'b11, 1'b0);
    beat(64'h11, 10'd8, 64'h22, 10'd8, 2'b11, 1'b1);
    total++; if (wr_data !== 128'h0123456789ABCDEF_FEDCBA9876542266) begin bad++; $display("FAIL edge_data got=%h exp=%h", wr_data, 128'h0123456789ABCDEF_FEDCBA9876542266); end
    accept();
    tick();
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; vd_addr = 5'd0; old_vd = '0; vsew = 3'd0; vl = 10'd0;
    beat_valid = 1'b0; lane_vd = '0; lane_idx = '0; lane_en = 2'b00; done_in = 1'b0;
    wr_ready = 1'b0;
    tick(); tick();
    test_reset();
    resetn = 1'b1;
    tick();
    test_reset();
    test_full_bytes();
    test_tail_and_hold();
    test_wide_elements();
    test_reset_mid();
    test_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
